// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes and default handler address.
package cp0_pkg;

    // CP0 register numbers as seen by mfc0/mtc0
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Exception codes recorded in cause[3:2]
    typedef enum logic [1:0] {
        EXC_INT    = 2'b00,
        EXC_SYS    = 2'b01,
        EXC_UNIMPL = 2'b10,
        EXC_OVR    = 2'b11
    } exc_code_t;

    // Default handler entry address
    localparam logic [31:0] EXC_BASE_DEFAULT = 32'h0000_0008;

endpackage

// File: rtl/intr_sync.sv
// Two-flop synchroniser bringing the asynchronous interrupt level into clk.
module intr_sync (
    input  logic clk,
    input  logic clrn,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Double-register the raw level; the first stage may go metastable
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0: Status/Cause/EPC, exception/interrupt arbitration and PC redirect.
module cp0_regs
    import cp0_pkg::*;
#(
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   EXC_BASE = DW'(EXC_BASE_DEFAULT)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [4:0]    rd_sel,
    output logic [DW-1:0] rd_data,
    input  logic [4:0]    wr_sel,
    input  logic [DW-1:0] wr_data,
    input  logic          mtc0,
    input  logic          eret,
    input  logic          stall,
    input  logic          exc_sys,
    input  logic          exc_unimpl,
    input  logic          exc_ovr,
    input  logic [DW-1:0] pc_in,
    input  logic          intr,
    output logic          inta,
    output logic          take_exc,
    output logic [DW-1:0] exc_target,
    output logic [DW-1:0] epc_out,
    output logic [DW-1:0] status_out,
    output logic [DW-1:0] cause_out
);

    logic [DW-1:0] r_status;
    logic [DW-1:0] r_cause;
    logic [DW-1:0] r_epc;
    logic          r_inta;

    logic          w_intr_s;
    logic          w_req_ovr;
    logic          w_req_unimpl;
    logic          w_req_sys;
    logic          w_req_int;
    logic          w_take;
    exc_code_t     w_code;

    intr_sync u_intr_sync (
        .clk     (clk),
        .clrn    (clrn),
        .i_async (intr),
        .o_sync  (w_intr_s)
    );

    // Each source is gated by its own Status enable bit
    assign w_req_ovr    = exc_ovr    & r_status[3];
    assign w_req_unimpl = exc_unimpl & r_status[2];
    assign w_req_sys    = exc_sys    & r_status[1];
    assign w_req_int    = w_intr_s   & r_status[0];

    // A stalled pipeline holds its requests, so nothing is lost by deferring
    assign w_take = (w_req_ovr | w_req_unimpl | w_req_sys | w_req_int) & ~stall;

    // Fixed priority: overflow, unimplemented, syscall, then interrupt
    always_comb begin
        w_code = EXC_INT;
        if (w_req_ovr)
            w_code = EXC_OVR;
        else if (w_req_unimpl)
            w_code = EXC_UNIMPL;
        else if (w_req_sys)
            w_code = EXC_SYS;
    end

    // Register update: exception entry beats eret, eret beats mtc0
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_status <= '0;
            r_cause  <= '0;
            r_epc    <= '0;
            r_inta   <= 1'b0;
        end else begin
            r_inta <= 1'b0;
            if (w_take) begin
                r_epc         <= pc_in;
                r_cause[3:2]  <= w_code;
                // Push the current mask nibble; new context starts fully masked
                r_status      <= {r_status[DW-5:0], 4'b0000};
                r_inta        <= (w_code == EXC_INT);
            end else if (eret) begin
                // Pop back to the interrupted context
                r_status <= {4'b0000, r_status[DW-1:4]};
            end else if (mtc0) begin
                case (wr_sel)
                    CP0_STATUS: r_status <= wr_data;
                    CP0_CAUSE:  r_cause  <= wr_data;
                    CP0_EPC:    r_epc    <= wr_data;
                    default:    ;
                endcase
            end
        end
    end

    // mfc0 read path; no write bypass, a same-cycle read sees the old value
    always_comb begin
        rd_data = '0;
        case (rd_sel)
            CP0_STATUS: rd_data = r_status;
            CP0_CAUSE:  rd_data = r_cause;
            CP0_EPC:    rd_data = r_epc;
            default:    rd_data = '0;
        endcase
    end

    assign take_exc   = w_take;
    assign exc_target = EXC_BASE;
    assign inta       = r_inta;
    assign epc_out    = r_epc;
    assign status_out = r_status;
    assign cause_out  = r_cause;

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed plan steps followed by random traffic.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic [4:0]  wr_sel;
    logic [31:0] wr_data;
    logic        mtc0, eret, stall, exc_sys, exc_unimpl, exc_ovr;
    logic [31:0] pc_in;
    logic        intr;
    logic        inta, take_exc;
    logic [31:0] exc_target, epc_out, status_out, cause_out;

    int n_cmp = 0;
    int n_err = 0;

    cp0_regs dut (
        .clk        (clk),
        .clrn       (clrn),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .mtc0       (mtc0),
        .eret       (eret),
        .stall      (stall),
        .exc_sys    (exc_sys),
        .exc_unimpl (exc_unimpl),
        .exc_ovr    (exc_ovr),
        .pc_in      (pc_in),
        .intr       (intr),
        .inta       (inta),
        .take_exc   (take_exc),
        .exc_target (exc_target),
        .epc_out    (epc_out),
        .status_out (status_out),
        .cause_out  (cause_out)
    );

    always #5 clk = ~clk;

    // Reference model: Status viewed as a stack of 8 mask nibbles, entry 0 is live
    logic [3:0]  m_nib [8];
    logic [31:0] m_cause;
    logic [31:0] m_epc;
    logic        m_inta;
    logic        m_hist [$];   // intr samples, newest first

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        for (int i = 0; i < 8; i++) s[i*4 +: 4] = m_nib[i];
        return s;
    endfunction

    function automatic logic m_intr_s();
        return (m_hist.size() > 1) ? m_hist[1] : 1'b0;
    endfunction

    // Winning code, or -1 when no enabled request is pending
    function automatic int m_winner();
        if (exc_ovr    && m_nib[0][3]) return 3;
        if (exc_unimpl && m_nib[0][2]) return 2;
        if (exc_sys    && m_nib[0][1]) return 1;
        if (m_intr_s() && m_nib[0][0]) return 0;
        return -1;
    endfunction

    function automatic logic m_take();
        return (m_winner() >= 0) && !stall;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] sel);
        if (sel == 5'd12) return m_status();
        if (sel == 5'd13) return m_cause;
        if (sel == 5'd14) return m_epc;
        return 32'h0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
        m_cause = 32'h0;
        m_epc   = 32'h0;
        m_inta  = 1'b0;
        m_hist.delete();
    endtask

    // Apply one clock edge to the model using the inputs present at that edge
    task automatic m_edge();
        int w;
        w = m_winner();
        if (m_take()) begin
            m_epc        = pc_in;
            m_cause[3:2] = 2'(w);
            for (int i = 7; i > 0; i--) m_nib[i] = m_nib[i-1];
            m_nib[0]     = 4'h0;
            m_inta       = (w == 0);
        end else begin
            m_inta = 1'b0;
            if (eret) begin
                for (int i = 0; i < 7; i++) m_nib[i] = m_nib[i+1];
                m_nib[7] = 4'h0;
            end else if (mtc0) begin
                if (wr_sel == 5'd12)
                    for (int i = 0; i < 8; i++) m_nib[i] = wr_data[i*4 +: 4];
                else if (wr_sel == 5'd13)
                    m_cause = wr_data;
                else if (wr_sel == 5'd14)
                    m_epc = wr_data;
            end
        end
        m_hist.push_front(intr);
        while (m_hist.size() > 2) void'(m_hist.pop_back());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check every output against the model away from the edge, then clock once
    task automatic cycle();
        @(negedge clk);
        chk("take_exc",   32'(take_exc), 32'(m_take()));
        chk("exc_target", exc_target, 32'h0000_0008);
        chk("rd_data",    rd_data, m_read(rd_sel));
        chk("epc_out",    epc_out, m_epc);
        chk("status_out", status_out, m_status());
        chk("cause_out",  cause_out, m_cause);
        chk("inta",       32'(inta), 32'(m_inta));
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rd_sel = 5'd0; wr_sel = 5'd0; wr_data = 32'h0;
        mtc0 = 1'b0; eret = 1'b0; stall = 1'b0;
        exc_sys = 1'b0; exc_unimpl = 1'b0; exc_ovr = 1'b0;
        pc_in = 32'h0; intr = 1'b0;
    endtask

    // Assert reset asynchronously, check the cleared state, release on a falling edge
    task automatic do_reset(input string tag);
        clrn = 1'b0;
        #1;
        m_reset();
        chk({tag, "_status"}, status_out, 32'h0);
        chk({tag, "_cause"},  cause_out,  32'h0);
        chk({tag, "_epc"},    epc_out,    32'h0);
        chk({tag, "_inta"},   32'(inta),  32'h0);
        chk({tag, "_take"},   32'(take_exc), 32'h0);
        chk({tag, "_rd"},     rd_data,    32'h0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic write_status(input logic [31:0] v);
        mtc0 = 1'b1; wr_sel = 5'd12; wr_data = v;
        cycle();
        mtc0 = 1'b0;
    endtask

    initial begin
        logic [31:0] epc_hold;
        int          sel_pick;

        idle_inputs();
        clrn = 1'b1;
        #3;
        do_reset("reset");

        // mtc0/mfc0 round trip and an unmapped read
        write_status(32'h0000_000F);
        rd_sel = 5'd12; #1;
        chk("mfc0_status", rd_data, 32'h0000_000F);
        cycle();
        rd_sel = 5'd5; #1;
        chk("mfc0_unmapped", rd_data, 32'h0);
        cycle();

        // Overflow exception entry
        exc_ovr = 1'b1; pc_in = 32'h0000_0040; #1;
        chk("ovr_take", 32'(take_exc), 32'h1);
        chk("ovr_target", exc_target, 32'h0000_0008);
        cycle();
        exc_ovr = 1'b0; #1;
        chk("ovr_epc", epc_out, 32'h0000_0040);
        chk("ovr_code", 32'(cause_out[3:2]), 32'h3);
        chk("ovr_status", status_out, 32'h0000_00F0);
        cycle();

        // Interrupt through the synchroniser
        write_status(32'h0000_000F);
        intr = 1'b1;
        cycle();
        cycle();
        #1;
        chk("int_take", 32'(take_exc), 32'h1);
        cycle();
        chk("int_inta", 32'(inta), 32'h1);
        chk("int_code", 32'(cause_out[3:2]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("int_masked", 32'(take_exc), 32'h0);
            chk("int_inta_once", 32'(inta), 32'h0);
        end
        intr = 1'b0;
        cycle(); cycle(); cycle();

        // Syscall and synchronised interrupt together; syscall wins
        write_status(32'h0000_000F);
        intr = 1'b1;
        cycle(); cycle();
        exc_sys = 1'b1; pc_in = 32'h0000_0300; #1;
        chk("sys_take", 32'(take_exc), 32'h1);
        cycle();
        exc_sys = 1'b0; #1;
        chk("sys_code", 32'(cause_out[3:2]), 32'h1);
        chk("sys_inta", 32'(inta), 32'h0);
        chk("sys_status", status_out, 32'h0000_00F0);
        eret = 1'b1; #1;
        chk("eret_no_take", 32'(take_exc), 32'h0);
        cycle();
        eret = 1'b0; #1;
        chk("eret_status", status_out, 32'h0000_000F);
        chk("eret_int_take", 32'(take_exc), 32'h1);
        cycle();
        chk("eret_int_inta", 32'(inta), 32'h1);
        intr = 1'b0;
        cycle(); cycle(); cycle();

        // Unimplemented instruction held off by a 3-cycle stall
        write_status(32'h0000_000F);
        epc_hold = epc_out;
        exc_unimpl = 1'b1; stall = 1'b1; pc_in = 32'h0000_0500;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_no_take", 32'(take_exc), 32'h0);
            cycle();
            chk("stall_epc", epc_out, epc_hold);
        end
        stall = 1'b0; #1;
        chk("unstall_take", 32'(take_exc), 32'h1);
        cycle();
        exc_unimpl = 1'b0; #1;
        chk("unimpl_status", status_out, 32'h0000_00F0);
        chk("unimpl_code", 32'(cause_out[3:2]), 32'h2);
        chk("unimpl_epc", epc_out, 32'h0000_0500);
        cycle();

        // Exception beats a same-cycle mtc0 to EPC, then reset mid-handler
        write_status(32'h0000_000F);
        mtc0 = 1'b1; wr_sel = 5'd14; wr_data = 32'h0000_0100;
        exc_ovr = 1'b1; pc_in = 32'h0000_0200; rd_sel = 5'd14;
        cycle();
        mtc0 = 1'b0; exc_ovr = 1'b0; #1;
        chk("mtc0_loses_epc", epc_out, 32'h0000_0200);
        chk("mtc0_loses_rd", rd_data, 32'h0000_0200);
        #2;
        do_reset("midreset");

        // Random traffic against the model; the device drops intr after inta
        for (int n = 0; n < 400; n++) begin
            if (m_inta) intr = 1'b0;
            else if (!intr && $urandom_range(0, 7) == 0) intr = 1'b1;
            stall      = ($urandom_range(0, 3) == 0);
            exc_ovr    = ($urandom_range(0, 7) == 0);
            exc_unimpl = ($urandom_range(0, 7) == 0);
            exc_sys    = ($urandom_range(0, 5) == 0);
            eret       = ($urandom_range(0, 7) == 0);
            mtc0       = ($urandom_range(0, 3) == 0);
            sel_pick   = int'($urandom_range(0, 3));
            wr_sel     = (sel_pick == 3) ? 5'($urandom) : 5'(12 + sel_pick);
            wr_data    = $urandom;
            if (wr_sel == 5'd12 && $urandom_range(0, 1) == 0) wr_data[3:0] = 4'hF;
            pc_in      = $urandom;
            rd_sel     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 14));
            cycle();
        end

        idle_inputs();
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 block for the interrupt/exception pipeline.
- Sits beside the general register file. The mtc0 source operand comes from the file's port-B read data. The mfc0 result feeds the file's write-data port through the WB mux.
- Holds the Status, Cause and EPC registers and synchronises the external interrupt.
- Arbitrates exception and interrupt requests and drives the PC-redirect controls: exception entry and eret.

Parameters:
- EXC_BASE, 32'h0000_0008, handler entry address driven on exc_target.
- DW, 32, CP0 register width.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- rd_sel  in  5  CP0 register number read by mfc0
- rd_data  out  DW  mfc0 read data
- wr_sel  in  5  CP0 register number written by mtc0
- wr_data  in  DW  mtc0 data (register-file port-B value)
- mtc0  in  1  write strobe
- eret  in  1  return-from-exception strobe
- stall  in  1  pipeline stalled; no exception may be taken this cycle
- exc_sys  in  1  syscall detected
- exc_unimpl  in  1  unimplemented instruction detected
- exc_ovr  in  1  arithmetic overflow detected
- pc_in  in  DW  PC to save into EPC (faulting PC for sync exceptions, next PC for interrupts)
- intr  in  1  external interrupt, asynchronous level
- inta  out  1  interrupt acknowledge pulse
- take_exc  out  1  redirect PC to exc_target this cycle
- exc_target  out  DW  equals EXC_BASE
- epc_out  out  DW  EPC value, eret target
- status_out  out  DW  Status register
- cause_out  out  DW  Cause register

Behaviour:
- Reset: status, cause, epc = 0; both synchroniser flops = 0; inta = 0.
  - take_exc, rd_data, epc_out, status_out, cause_out therefore read 0.
  - Reset is honoured at any point, including mid-handler; nothing survives it.
- Interrupt sync: intr passes through two flops to give intr_s. It is a level and is held until inta; the device drops intr after seeing inta.
- Status bit masks:
  - [0] enables the interrupt.
  - [1] enables syscall, [2] unimplemented, [3] overflow.
  - [31:4] is a nested-context stack, 4 bits per level.
- Requests:
  - r_ovr = exc_ovr & status[3]
  - r_unimpl = exc_unimpl & status[2]
  - r_sys = exc_sys & status[1]
  - r_int = intr_s & status[0]
- Priority: ovr > unimpl > sys > int. Codes: int=2'b00, sys=2'b01, unimpl=2'b10, ovr=2'b11.
- take_exc = (any request) & ~stall. It is combinational. exc_target is the constant EXC_BASE.
- On a clock edge with take_exc=1:
  - epc <= pc_in
  - cause[3:2] <= winning code; other cause bits unchanged
  - status <= {status[27:0], 4'b0}, which masks everything
  - inta <= 1 for exactly one cycle if the winner was int, else 0
- On a clock edge with eret=1 and take_exc=0: status <= {4'b0, status[31:4]}.
- mtc0 with take_exc=0 and eret=0:
  - wr_sel 12 writes status, 13 writes cause, 14 writes epc.
  - Any other wr_sel is ignored.
- Simultaneous events:
  - take_exc beats eret and mtc0; the faulting instruction is flushed.
  - eret beats mtc0; decode never issues both together.
- rd_data is combinational: sel 12 → status, 13 → cause, 14 → epc, other → 0. A read in the same cycle as a write returns the old value; there is no bypass.
- epc_out, status_out and cause_out are direct register outputs.
- Stall: requests are not lost. Sync exception inputs are re-presented by the held pipeline, and intr_s is a level.
- Nesting depth is 7. An 8th entry shifts the oldest context out; that is accepted by design.

Decomposition:
- Package cp0_pkg holds:
  - CP0 register numbers STATUS=12, CAUSE=13, EPC=14
  - 2-bit exception-code constants
  - default EXC_BASE
- One sub-module: intr_sync, the 2-flop synchroniser with clk/clrn.

Test Plan:
- Reset, then mtc0 sel12 ← 32'h0000_000F; mfc0 sel12 → 32'h0000_000F; mfc0 sel 5 → 0.
- Status=F, exc_ovr=1, pc_in=32'h0000_0040:
  - take_exc=1, exc_target=32'h8 in the same cycle.
  - Next cycle: epc=32'h40, cause[3:2]=2'b11, status=32'hF0.
- Status=F, intr raised at cycle 0:
  - take_exc=1 at cycle 2.
  - inta=1 for exactly one cycle after that edge; cause[3:2]=2'b00.
  - With intr held and status[0]=0, no second take_exc.
- Status=F, exc_sys=1 and intr_s=1 together: sys wins (code 2'b01), inta stays 0. After eret, status returns to F and the interrupt is then taken.
- exc_unimpl with stall=1 for 3 cycles: take_exc=0 and epc unchanged; after stall drops, take_exc=1 and status is shifted.
- mtc0 sel14 ← 32'h100 in the same cycle as a taken exception with pc_in=32'h200: epc=32'h200. Assert clrn=0 mid-handler: all registers read 0 immediately.
